nes_pad_poller: RTL
===================

// Module: nes_pad_poller
// PURPOSE
//  Polling sequencer for NES pads sharing one latch/clock pair; one serial data line per pad.
//  Generates latch and serial-clock pulses, samples each pad's data line, and commits 8-bit button words.
//  Emits pressed/released edge masks once per poll, so game logic reads one coherent snapshot per frame.
//  Sits between the pad connector pins and game/video logic, clocked from the 900 kHz domain.
// PARAMETERS
//  NUM_PADS   2      pads sharing pad_latch/pad_clk; one data line each
//  LATCH_CYC  11     cycles pad_latch is held high (~12 us at 900 kHz)
//  HALF_CYC   5      cycles per pad_clk half-period; legal range >= 3
//  POLL_DIV   15000  cycles between automatic polls (60 Hz at 900 kHz); legal range > poll length
// PORTS
//  clk_900KHz  in   1           system clock; all logic is on its rising edge
//  reset       in   1           asynchronous, active-low reset
//  enable      in   1           1 = automatic polling every POLL_DIV cycles
//  poll_req    in   1           single-cycle request for an immediate poll
//  pad_data    in   NUM_PADS    raw serial data per pad, active-low, asynchronous to clk
//  pad_latch   out  1           latch pulse to all pads, active-high
//  pad_clk     out  1           serial clock to all pads; idles high
//  buttons     out  NUM_PADS*8  committed state, active-high; pad p at [8p+7:8p]
//  pressed     out  NUM_PADS*8  bits that went 0->1 at the last commit; valid with frame_valid
//  released    out  NUM_PADS*8  bits that went 1->0 at the last commit; valid with frame_valid
//  frame_valid out  1           1-cycle strobe on the commit cycle
//  busy        out  1           high from LATCH entry through DONE
// BEHAVIOUR
//  Reset (async assert, sync release): pad_latch=0, pad_clk=1, buttons/pressed/released=0,
//   frame_valid=0, busy=0, FSM=IDLE, poll timer=0, pending=0.
//  Bit order within each pad byte: 0=A, 1=B, 2=Select, 3=Start, 4=Up, 5=Down, 6=Left, 7=Right.
//  Each pad_data bit passes through a 2-flop synchronizer before any sampling.
//  Poll timer: while enable=1, counts 0..POLL_DIV-1 and raises a tick on wrap.
//   While enable=0, the timer holds at 0.
//  Trigger = tick OR poll_req.
//   In IDLE, a trigger enters LATCH on the next cycle.
//   While busy, a trigger sets pending (one deep; extra triggers merge). pending starts a new poll in
//   the cycle after DONE.
//  FSM:
//   IDLE  : latch=0, clk=1.
//   LATCH : latch=1 for LATCH_CYC cycles, then go to CLK_LO with bit=0.
//   CLK_LO: clk=0 for HALF_CYC cycles. On the last cycle, shift in ~sync_data[p] as bit[bit] of each pad.
//   CLK_HI: clk=1 for HALF_CYC cycles. Then go to CLK_LO with bit+1; after bit 7, go to DONE.
//   DONE  : 1 cycle. Compute new = shifted word, pressed = new & ~buttons, released = ~new & buttons.
//           Then buttons <= new and frame_valid = 1. Then go to IDLE, or to LATCH if pending.
//  Poll length: LATCH_CYC + 16*HALF_CYC + 1 cycles (default 92).
//   pad_latch rises in the cycle after the trigger.
//  pressed/released are registered and hold until the next DONE.
//   Consumers sample them only when frame_valid = 1.
//  enable falling mid-poll: the current poll completes; pending is still honoured.
//  Reset mid-poll: everything returns to reset values immediately; the partial word is discarded.
//  Disconnected pad: data reads high, which gives all-zero buttons.
//  Shifted bits never reach buttons before DONE; no partial updates are ever visible.
//  poll_req coincident with a tick: a single poll is started.
// STRUCTURE
//  nes_pkg:
//   - NES_BITS = 8
//   - button index localparams (BTN_A..BTN_RIGHT)
//   - typedef enum logic [2:0] {IDLE, LATCH, CLK_LO, CLK_HI, DONE} nes_poll_state_t
//  Sub-module nes_pad_shifter:
//   - one instance per pad
//   - contains the 2-flop synchronizer, the 8-bit shift register and the edge-mask logic
//   - inputs: sample, commit
//  The top level holds the FSM, the phase/bit counters, the poll timer and the pending flag.
// TESTING
//  Reset: assert reset=0 mid-CLK_LO -> pad_latch=0, pad_clk=1, buttons=0, busy=0 within the same cycle.
//  poll_req with pad0 model pressing A+Start (byte 8'h09) and pad1 idle ->
//   - pad_latch high 11 cycles, then 8 clk pulses of 5 low/5 high
//   - frame_valid at cycle 92, buttons=16'h0009, pressed=16'h0009
//  Second poll after pad0 releases A and presses Right ->
//   - buttons=16'h0088
//   - pressed=16'h0080, released=16'h0001
//  enable=1 for 45000 cycles -> exactly 3 frame_valid strobes, spaced 15000 cycles apart.
//  poll_req twice during busy -> exactly one extra poll, with pad_latch rising the cycle after DONE.
//  pad_data held at 1 on both pads -> buttons=0 and pressed=0 every frame; data glitch mid-CLK_HI is ignored.

Source files
------------

// File: rtl/nes_pkg.sv
// Shared constants, button bit positions and poll FSM states for the NES pad poller.
package nes_pkg;

   localparam int unsigned NES_BITS  = 8;
   localparam int unsigned NES_IDX_W = 3;

   localparam int unsigned BTN_A      = 0;
   localparam int unsigned BTN_B      = 1;
   localparam int unsigned BTN_SELECT = 2;
   localparam int unsigned BTN_START  = 3;
   localparam int unsigned BTN_UP     = 4;
   localparam int unsigned BTN_DOWN   = 5;
   localparam int unsigned BTN_LEFT   = 6;
   localparam int unsigned BTN_RIGHT  = 7;

   typedef enum logic [2:0] {
      IDLE,
      LATCH,
      CLK_LO,
      CLK_HI,
      DONE
   } nes_poll_state_t;

endpackage

// File: rtl/nes_pad_poller_if.sv
// Pad-pin and game-side signal bundle for nes_pad_poller; master is the poller.
interface nes_pad_poller_if #(
   parameter int unsigned NUM_PADS = 2
);

   localparam int unsigned WORD_W = NUM_PADS * nes_pkg::NES_BITS;

   logic                enable;
   logic                poll_req;
   logic [NUM_PADS-1:0] pad_data;
   logic                pad_latch;
   logic                pad_clk;
   logic [WORD_W-1:0]   buttons;
   logic [WORD_W-1:0]   pressed;
   logic [WORD_W-1:0]   released;
   logic                frame_valid;
   logic                busy;

   modport master (
      input  enable, poll_req, pad_data,
      output pad_latch, pad_clk, buttons, pressed, released, frame_valid, busy
   );

   modport slave (
      output enable, poll_req, pad_data,
      input  pad_latch, pad_clk, buttons, pressed, released, frame_valid, busy
   );

endinterface

// File: rtl/nes_pad_shifter.sv
// Per-pad data path: input synchronizer, serial capture register and commit-time edge masks.
module nes_pad_shifter
   import nes_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 i_pad_data,
   input  logic                 i_sample,
   input  logic [NES_IDX_W-1:0] i_bit_idx,
   input  logic                 i_commit,
   output logic [NES_BITS-1:0]  o_buttons,
   output logic [NES_BITS-1:0]  o_pressed,
   output logic [NES_BITS-1:0]  o_released
);

   logic [1:0]          r_sync;
   logic [NES_BITS-1:0] r_shift;
   logic [NES_BITS-1:0] r_buttons;
   logic [NES_BITS-1:0] r_pressed;
   logic [NES_BITS-1:0] r_released;

   // Idle line is high (released), so the synchronizer resets to that level
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync <= 2'b11;
      end else begin
         r_sync <= {r_sync[0], i_pad_data};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shift <= '0;
      end else if (i_sample) begin
         r_shift[i_bit_idx] <= ~r_sync[1];
      end
   end

   // Capture word stays private until commit so no partial frame is ever visible
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_buttons  <= '0;
         r_pressed  <= '0;
         r_released <= '0;
      end else if (i_commit) begin
         r_buttons  <= r_shift;
         r_pressed  <= r_shift & ~r_buttons;
         r_released <= ~r_shift & r_buttons;
      end
   end

   assign o_buttons  = r_buttons;
   assign o_pressed  = r_pressed;
   assign o_released = r_released;

endmodule

// File: rtl/nes_pad_poller.sv
// NES pad polling sequencer: latch/clock pulse generation, poll timer, pending request and per-pad capture.
module nes_pad_poller
   import nes_pkg::*;
#(
   parameter int unsigned NUM_PADS  = 2,
   parameter int unsigned LATCH_CYC = 11,
   parameter int unsigned HALF_CYC  = 5,
   parameter int unsigned POLL_DIV  = 15000
) (
   input  logic              clk_900KHz,
   input  logic              reset,
   nes_pad_poller_if.master  bus
);

   localparam int unsigned WORD_W = NUM_PADS * NES_BITS;
   localparam int unsigned PH_MAX = (LATCH_CYC > HALF_CYC) ? LATCH_CYC : HALF_CYC;
   localparam int unsigned PH_W   = $clog2(PH_MAX);
   localparam int unsigned TMR_W  = $clog2(POLL_DIV);

   nes_poll_state_t        r_state;
   nes_poll_state_t        w_state_next;
   logic [PH_W-1:0]        r_phase;
   logic [PH_W-1:0]        w_phase_next;
   logic [NES_IDX_W-1:0]   r_bit;
   logic [NES_IDX_W-1:0]   w_bit_next;
   logic [TMR_W-1:0]       r_timer;
   logic                   r_pending;
   logic                   w_pending_next;
   logic                   r_pad_latch;
   logic                   r_pad_clk;
   logic                   r_frame_valid;
   logic                   r_busy;
   logic                   w_tick;
   logic                   w_trigger;
   logic                   w_sample;
   logic                   w_commit;
   logic [WORD_W-1:0]      w_buttons;
   logic [WORD_W-1:0]      w_pressed;
   logic [WORD_W-1:0]      w_released;

   assign w_tick    = bus.enable && (r_timer == TMR_W'(POLL_DIV - 1));
   assign w_trigger = w_tick || bus.poll_req;

   // Free-running frame timer, parked at zero while automatic polling is off
   always_ff @(posedge clk_900KHz or negedge reset) begin
      if (!reset) begin
         r_timer <= '0;
      end else if (!bus.enable || w_tick) begin
         r_timer <= '0;
      end else begin
         r_timer <= r_timer + TMR_W'(1);
      end
   end

   always_ff @(posedge clk_900KHz or negedge reset) begin
      if (!reset) begin
         r_state   <= IDLE;
         r_phase   <= '0;
         r_bit     <= '0;
         r_pending <= 1'b0;
      end else begin
         r_state   <= w_state_next;
         r_phase   <= w_phase_next;
         r_bit     <= w_bit_next;
         r_pending <= w_pending_next;
      end
   end

   always_comb begin
      w_state_next   = r_state;
      w_phase_next   = r_phase;
      w_bit_next     = r_bit;
      w_pending_next = r_pending;
      w_sample       = 1'b0;
      w_commit       = 1'b0;

      case (r_state)
         IDLE: begin
            if (w_trigger) begin
               w_state_next = LATCH;
               w_phase_next = '0;
            end
         end
         LATCH: begin
            if (r_phase == PH_W'(LATCH_CYC - 1)) begin
               w_state_next = CLK_LO;
               w_phase_next = '0;
               w_bit_next   = '0;
            end else begin
               w_phase_next = r_phase + PH_W'(1);
            end
         end
         CLK_LO: begin
            if (r_phase == PH_W'(HALF_CYC - 1)) begin
               w_sample     = 1'b1;
               w_state_next = CLK_HI;
               w_phase_next = '0;
            end else begin
               w_phase_next = r_phase + PH_W'(1);
            end
         end
         CLK_HI: begin
            if (r_phase == PH_W'(HALF_CYC - 1)) begin
               w_phase_next = '0;
               if (r_bit == NES_IDX_W'(NES_BITS - 1)) begin
                  w_state_next = DONE;
                  w_commit     = 1'b1;
               end else begin
                  w_state_next = CLK_LO;
                  w_bit_next   = r_bit + NES_IDX_W'(1);
               end
            end else begin
               w_phase_next = r_phase + PH_W'(1);
            end
         end
         DONE: begin
            w_phase_next = '0;
            w_state_next = (r_pending || w_trigger) ? LATCH : IDLE;
         end
         default: begin
            w_state_next = IDLE;
            w_phase_next = '0;
            w_bit_next   = '0;
         end
      endcase

      // DONE consumes any request seen so far; elsewhere a busy-time request is remembered once
      if (r_state == DONE) begin
         w_pending_next = 1'b0;
      end else if (r_state != IDLE && w_trigger) begin
         w_pending_next = 1'b1;
      end
   end

   // Pin and status outputs are registered from the next state so they line up with it
   always_ff @(posedge clk_900KHz or negedge reset) begin
      if (!reset) begin
         r_pad_latch   <= 1'b0;
         r_pad_clk     <= 1'b1;
         r_frame_valid <= 1'b0;
         r_busy        <= 1'b0;
      end else begin
         r_pad_latch   <= (w_state_next == LATCH);
         r_pad_clk     <= (w_state_next != CLK_LO);
         r_frame_valid <= (w_state_next == DONE);
         r_busy        <= (w_state_next != IDLE);
      end
   end

   for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
      nes_pad_shifter u_shifter (
         .clk        (clk_900KHz),
         .rst_n      (reset),
         .i_pad_data (bus.pad_data[p]),
         .i_sample   (w_sample),
         .i_bit_idx  (r_bit),
         .i_commit   (w_commit),
         .o_buttons  (w_buttons[p*NES_BITS +: NES_BITS]),
         .o_pressed  (w_pressed[p*NES_BITS +: NES_BITS]),
         .o_released (w_released[p*NES_BITS +: NES_BITS])
      );
   end

   assign bus.pad_latch   = r_pad_latch;
   assign bus.pad_clk     = r_pad_clk;
   assign bus.frame_valid = r_frame_valid;
   assign bus.busy        = r_busy;
   assign bus.buttons     = w_buttons;
   assign bus.pressed     = w_pressed;
   assign bus.released    = w_released;

endmodule
